// File: rtl/rtype_issue_if.sv
// Handshake and ALU field bus between the instruction source, rtype_issue and the ALU.
interface rtype_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic        issue_valid;
  logic        issue_done;
  logic        illegal;
  logic        busy;
  logic [15:0] issued_count;
  logic [15:0] illegal_count;

  modport master (
    output in_valid, in_instr,
    input  in_ready, rs, rt, rd, shamt, funct,
    input  issue_valid, issue_done, illegal, busy, issued_count, illegal_count
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, rs, rt, rd, shamt, funct,
    output issue_valid, issue_done, illegal, busy, issued_count, illegal_count
  );
endinterface

// File: rtl/rtype_issue.sv
// R-type issue sequencer: FIFO-buffered MIPS words decoded onto a held ALU field bus.
// Define RTYPE_ISSUE_COUNT_EN to build the saturating issued/illegal counters.
module rtype_issue #(
  parameter int FIFO_DEPTH  = 4,
  parameter int EXEC_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  rtype_issue_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(EXEC_CYCLES + 1);

  typedef enum logic {IDLE, EXEC} state_t;

  function automatic logic is_legal(input logic [31:0] w);
    logic ok;
    ok = 1'b0;
    if (w[31:26] == 6'b000000) begin
      case (w[5:0])
        6'b100000, 6'b100010, 6'b100100,
        6'b100101, 6'b101010, 6'b000010: ok = 1'b1;
        default:                         ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   occ;
  logic [31:0]      head;
  logic             push, pop, load, drop, done;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             illegal_p1;
  logic [4:0]       rs_q, rt_q, rd_q, shamt_q;
  logic [5:0]       funct_q;

  assign bus.in_ready = (occ != (PTR_W+1)'(FIFO_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign head         = mem[rd_ptr];

  // Storage is not reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (occ != '0) begin
          pop = 1'b1;
          if (is_legal(head)) begin
            load      = 1'b1;
            state_nxt = EXEC;
          end else begin
            drop = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt == CNT_W'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Decode stage: fields captured from the head entry at the pop edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      shamt_q    <= '0;
      funct_q    <= '0;
      cnt        <= '0;
      illegal_p1 <= 1'b0;
    end else begin
      illegal_p1 <= drop;
      if (load) begin
        rs_q    <= head[25:21];
        rt_q    <= head[20:16];
        rd_q    <= head[15:11];
        shamt_q <= head[10:6];
        funct_q <= head[5:0];
        cnt     <= CNT_W'(EXEC_CYCLES);
      end else if (state == EXEC) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign bus.rs          = rs_q;
  assign bus.rt          = rt_q;
  assign bus.rd          = rd_q;
  assign bus.shamt       = shamt_q;
  assign bus.funct       = funct_q;
  assign bus.issue_valid = (state == EXEC);
  assign bus.issue_done  = done;
  assign bus.illegal     = illegal_p1;
  assign bus.busy        = (occ != '0) || (state == EXEC);

`ifdef RTYPE_ISSUE_COUNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] issued_q, illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q  <= '0;
      illegal_q <= '0;
    end else begin
      if (done) issued_q  <= sat_inc(issued_q);
      if (drop) illegal_q <= sat_inc(illegal_q);
    end
  end

  assign bus.issued_count  = issued_q;
  assign bus.illegal_count = illegal_q;
`else
  assign bus.issued_count  = 16'd0;
  assign bus.illegal_count = 16'd0;
`endif
endmodule
